// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   pc_state_t  : sequencer state encoding (IDLE, RUN, FLUSH, DONE)
//   PC_W        : default program counter / branch offset width
//   HOLD_OFFSET : branch offset that means "stay on this instruction"
package pc_pkg;

   localparam int PC_W        = 12;
   localparam int HOLD_OFFSET = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } pc_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selector for the sequencer.
// Ports:
//   pc           : current program counter
//   target       : signed branch offset from the branch-target block
//   branch_taken : current instruction is a branch with a true condition
//   halt         : current instruction is halt
//   next_pc      : PC for the next fetch, assuming the current one retires
//   take_branch  : a real (non-zero offset) branch is taken; a bubble follows
module pc_next_calc
   import pc_pkg::*;
#(
   parameter int D = PC_W
) (
   input  logic                pc_unused_guard,
   input  logic [D-1:0]        pc,
   input  logic signed [D-1:0] target,
   input  logic                branch_taken,
   input  logic                halt,
   output logic [D-1:0]        next_pc,
   output logic                take_branch
);

   logic hold_pc;

   // A zero offset is the LUT default entry: re-execute the same address.
   assign hold_pc     = branch_taken && (target == D'(HOLD_OFFSET));
   assign take_branch = branch_taken && !halt && !hold_pc;

   always_comb begin
      next_pc = pc + 1'b1;
      if (halt || hold_pc) begin
         next_pc = pc;
      end else if (take_branch) begin
         // Offset is already D bits wide; the sum wraps modulo 2^D.
         next_pc = pc + $unsigned(target);
      end
   end

   logic unused;
   assign unused = pc_unused_guard;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch from START_ADDR until halt, with relative
// branches costing one extra bubble cycle and a terminal DONE state.
// Ports:
//   Clk, Reset   : clock, synchronous active-high reset
//   Start        : pulse; (re)starts execution from IDLE or DONE
//   branch_taken : current instruction is a taken branch
//   target       : signed branch offset
//   halt         : current instruction is halt
//   prog_ctr     : fetch address
//   fetch_valid  : prog_ctr holds a real instruction
//   done         : sequencer is in DONE
//   cycle_cnt    : saturating count of RUN + FLUSH cycles since Start
//   instr_cnt    : saturating count of retired instructions since Start
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int          D          = PC_W,
   parameter int unsigned START_ADDR = 0,
   parameter int          CNT_W      = 16
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Start,
   input  logic                branch_taken,
   input  logic signed [D-1:0] target,
   input  logic                halt,
   output logic [D-1:0]        prog_ctr,
   output logic                fetch_valid,
   output logic                done,
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [CNT_W-1:0]    instr_cnt
);

   localparam logic [D-1:0] START_PC = D'(START_ADDR);

   pc_state_t        state;
   pc_state_t        next_state;
   logic [D-1:0]     calc_pc;
   logic             take_branch;
   logic [D-1:0]     pc_d;
   logic [CNT_W-1:0] cyc_d;
   logic [CNT_W-1:0] ins_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   pc_next_calc #(.D(D)) u_next (
      .pc_unused_guard (1'b0),
      .pc              (prog_ctr),
      .target          (target),
      .branch_taken    (branch_taken),
      .halt            (halt),
      .next_pc         (calc_pc),
      .take_branch     (take_branch)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (Start) next_state = RUN;
         RUN: begin
            if (halt)             next_state = DONE;
            else if (take_branch) next_state = FLUSH;
         end
         FLUSH:   next_state = RUN;
         DONE:    if (Start) next_state = RUN;
         default: next_state = IDLE;
      endcase
   end

   // Next values of the registered outputs; everything defaults to hold.
   always_comb begin
      pc_d  = prog_ctr;
      cyc_d = cycle_cnt;
      ins_d = instr_cnt;
      unique case (state)
         IDLE, DONE: begin
            if (Start) begin
               pc_d  = START_PC;
               cyc_d = '0;
               ins_d = '0;
            end
         end
         RUN: begin
            pc_d  = calc_pc;
            cyc_d = sat_inc(cycle_cnt);
            ins_d = sat_inc(instr_cnt);
         end
         FLUSH: begin
            cyc_d = sat_inc(cycle_cnt);
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         prog_ctr    <= START_PC;
         cycle_cnt   <= '0;
         instr_cnt   <= '0;
         fetch_valid <= 1'b0;
         done        <= 1'b0;
      end else begin
         prog_ctr    <= pc_d;
         cycle_cnt   <= cyc_d;
         instr_cnt   <= ins_d;
         fetch_valid <= (next_state == RUN);
         done        <= (next_state == DONE);
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (D=12, START_ADDR=0, CNT_W=16).
module tb_pc_sequencer;

   logic              Clk = 1'b0;
   logic              Reset = 1'b1;
   logic              Start = 1'b0;
   logic              branch_taken = 1'b0;
   logic signed [11:0] target = '0;
   logic              halt = 1'b0;
   logic [11:0]       prog_ctr;
   logic              fetch_valid;
   logic              done;
   logic [15:0]       cycle_cnt;
   logic [15:0]       instr_cnt;

   int checks = 0;
   int failures = 0;

   pc_sequencer #(.D(12), .START_ADDR(0), .CNT_W(16)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Start        (Start),
      .branch_taken (branch_taken),
      .target       (target),
      .halt         (halt),
      .prog_ctr     (prog_ctr),
      .fetch_valid  (fetch_valid),
      .done         (done),
      .cycle_cnt    (cycle_cnt),
      .instr_cnt    (instr_cnt)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic expect_all(input string tag, input logic [11:0] pc, input logic fv,
                             input logic dn, input logic [15:0] cyc, input logic [15:0] ins);
      check({tag, ".pc"},   32'(prog_ctr),    32'(pc));
      check({tag, ".fv"},   32'(fetch_valid), 32'(fv));
      check({tag, ".done"}, 32'(done),        32'(dn));
      check({tag, ".cyc"},  32'(cycle_cnt),   32'(cyc));
      check({tag, ".ins"},  32'(instr_cnt),   32'(ins));
   endtask

   task automatic reset_and_start();
      branch_taken = 1'b0; halt = 1'b0; target = '0;
      Reset = 1'b1; tick();
      Reset = 1'b0; Start = 1'b1; tick();
      Start = 1'b0;
   endtask

   initial begin
      // Reset state
      tick(); tick();
      expect_all("reset", 12'h000, 1'b0, 1'b0, 16'd0, 16'd0);
      Reset = 1'b0;
      tick();
      expect_all("idle_hold", 12'h000, 1'b0, 1'b0, 16'd0, 16'd0);

      // Sequential fetch from start
      Start = 1'b1; tick(); Start = 1'b0;
      expect_all("start", 12'h000, 1'b1, 1'b0, 16'd0, 16'd0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("seq.pc", 32'(prog_ctr), i);
         check("seq.fv", 32'(fetch_valid), 1);
      end
      expect_all("seq4", 12'h004, 1'b1, 1'b0, 16'd4, 16'd4);

      // Forward branch at pc=10, halt/branch ignored during the bubble
      repeat (6) tick();
      check("pc10", 32'(prog_ctr), 10);
      branch_taken = 1'b1; target = 12'sd20; tick();
      expect_all("br_fwd", 12'd30, 1'b0, 1'b0, 16'd11, 16'd11);
      halt = 1'b1; target = 12'sd5; tick();
      halt = 1'b0; branch_taken = 1'b0; target = '0;
      expect_all("flush", 12'd30, 1'b1, 1'b0, 16'd12, 16'd11);
      tick();
      expect_all("after_flush", 12'd31, 1'b1, 1'b0, 16'd13, 16'd12);

      // Negative branch wraps below zero, sequential wrap at top, Start ignored in RUN
      reset_and_start();
      tick(); tick();
      check("pc2", 32'(prog_ctr), 2);
      branch_taken = 1'b1; target = 12'hFFB; tick();
      branch_taken = 1'b0; target = '0;
      expect_all("br_neg", 12'hFFD, 1'b0, 1'b0, 16'd3, 16'd3);
      tick();
      expect_all("neg_flush", 12'hFFD, 1'b1, 1'b0, 16'd4, 16'd3);
      tick();
      check("pcFFE", 32'(prog_ctr), 12'hFFE);
      Start = 1'b1; tick(); Start = 1'b0;
      expect_all("start_in_run", 12'hFFF, 1'b1, 1'b0, 16'd6, 16'd5);
      tick();
      expect_all("wrap0", 12'h000, 1'b1, 1'b0, 16'd7, 16'd6);

      // Zero-offset branch holds pc and retires each repetition
      reset_and_start();
      repeat (7) tick();
      check("pc7", 32'(prog_ctr), 7);
      branch_taken = 1'b1; target = '0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("hold.pc", 32'(prog_ctr), 7);
         check("hold.fv", 32'(fetch_valid), 1);
         check("hold.ins", 32'(instr_cnt), 7 + i);
      end
      branch_taken = 1'b0; tick();
      expect_all("hold_exit", 12'd8, 1'b1, 1'b0, 16'd11, 16'd11);

      // Halt beats a simultaneous branch; DONE holds; Start restarts
      reset_and_start();
      repeat (5) tick();
      halt = 1'b1; branch_taken = 1'b1; target = 12'sd20; tick();
      halt = 1'b0; branch_taken = 1'b0; target = '0;
      expect_all("halt", 12'd5, 1'b0, 1'b1, 16'd6, 16'd6);
      tick(); tick();
      expect_all("done_hold", 12'd5, 1'b0, 1'b1, 16'd6, 16'd6);
      Start = 1'b1; tick(); Start = 1'b0;
      expect_all("restart", 12'd0, 1'b1, 1'b0, 16'd0, 16'd0);

      // Reset during FLUSH aborts; Start coincident with Reset ignored
      branch_taken = 1'b1; target = 12'sd20; tick();
      branch_taken = 1'b0; target = '0;
      expect_all("pre_rst_flush", 12'd20, 1'b0, 1'b0, 16'd1, 16'd1);
      Reset = 1'b1; Start = 1'b1; tick();
      Reset = 1'b0; Start = 1'b0;
      expect_all("rst_flush", 12'd0, 1'b0, 1'b0, 16'd0, 16'd0);
      tick();
      expect_all("rst_idle", 12'd0, 1'b0, 1'b0, 16'd0, 16'd0);

      // Counter saturation via long zero-offset hold
      reset_and_start();
      branch_taken = 1'b1; target = '0;
      repeat (65540) @(posedge Clk);
      #1;
      expect_all("sat", 12'd0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
      branch_taken = 1'b0; tick();
      expect_all("sat_step", 12'd1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
